// File: rtl/conv_sequencer.sv
// conv_sequencer: frame-level control for the KxK convolver datapath.
// Loads weights, streams raster pixels, tracks windows through the pipe.
module conv_sequencer #(
    parameter int KERN_DIM   = 5,
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int DP_LAT     = 3
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    input  logic                                 w_valid,
    output logic                                 w_ready,
    output logic                                 w_we,
    output logic [$clog2(KERN_DIM*KERN_DIM)-1:0] w_addr,
    input  logic                                 px_valid,
    output logic                                 px_ready,
    output logic                                 px_we,
    output logic                                 win_valid,
    output logic                                 dp_ce,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(IMG_H)-1:0]             out_row,
    output logic [$clog2(IMG_W)-1:0]             out_col
);

    localparam int NW  = KERN_DIM * KERN_DIM;
    localparam int WAW = $clog2(NW);
    localparam int RW  = $clog2(IMG_H);
    localparam int CW  = $clog2(IMG_W);

    // Data words never pass through here; the width only sizes the parent.
    if (DATA_WIDTH > 0) begin : g_dw_ok
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    state_t          nstate;
    logic [WAW-1:0]  wcnt;
    logic [RW-1:0]   r;
    logic [CW-1:0]   c;
    logic            last_px;
    logic [DP_LAT-1:0] vld;
    logic [RW-1:0]   prow [DP_LAT];
    logic [CW-1:0]   pcol [DP_LAT];

    // Handshake strobes and the global stall enable.
    always_comb begin
        dp_ce     = ~out_valid | out_ready;
        w_we      = w_valid & w_ready;
        px_we     = px_valid & px_ready;
        last_px   = (r == RW'(IMG_H - 1)) && (c == CW'(IMG_W - 1));
        win_valid = px_we
                  & (r >= RW'(KERN_DIM - 1))
                  & (c >= CW'(KERN_DIM - 1));
        w_addr    = wcnt;
        out_valid = vld[DP_LAT-1];
        out_row   = prow[DP_LAT-1];
        out_col   = pcol[DP_LAT-1];
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Next-state and per-state handshake outputs.
    always_comb begin
        nstate   = state;
        busy     = 1'b1;
        done     = 1'b0;
        w_ready  = 1'b0;
        px_ready = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) nstate = LOAD_W;
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && wcnt == WAW'(NW - 1)) nstate = STREAM;
            end
            STREAM: begin
                px_ready = dp_ce;
                if (px_valid && dp_ce && last_px) nstate = DRAIN;
            end
            DRAIN: begin
                if (vld == '0) nstate = DONE;
            end
            DONE: begin
                done   = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    // Weight index and raster position counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt <= '0;
            r    <= '0;
            c    <= '0;
        end else if (state == IDLE && start) begin
            wcnt <= '0;
            r    <= '0;
            c    <= '0;
        end else begin
            if (w_we) wcnt <= wcnt + 1'b1;
            if (px_we) begin
                if (c == CW'(IMG_W - 1)) begin
                    c <= '0;
                    r <= r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
            end
        end
    end

    // Valid/coordinate pipe mirroring the datapath latency; frozen on stall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld <= '0;
            for (int i = 0; i < DP_LAT; i++) begin
                prow[i] <= '0;
                pcol[i] <= '0;
            end
        end else if (dp_ce) begin
            vld[0] <= win_valid;
            if (win_valid) begin
                prow[0] <= r - RW'(KERN_DIM - 1);
                pcol[0] <= c - CW'(KERN_DIM - 1);
            end
            for (int i = 1; i < DP_LAT; i++) begin
                vld[i]  <= vld[i-1];
                prow[i] <= prow[i-1];
                pcol[i] <= pcol[i-1];
            end
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: scenario bench for conv_sequencer, K=3, 6x6, latency 2.
// Expected window coordinates are queued at pixel accept, popped at transfer.
module tb_conv_sequencer;

    localparam int K = 3;
    localparam int W = 6;
    localparam int H = 6;
    localparam int L = 2;
    localparam int NOUT = (W - K + 1) * (H - K + 1);

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       busy;
    logic       done;
    logic       w_valid;
    logic       w_ready;
    logic       w_we;
    logic [3:0] w_addr;
    logic       px_valid;
    logic       px_ready;
    logic       px_we;
    logic       win_valid;
    logic       dp_ce;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_row;
    logic [2:0] out_col;

    int checks = 0;
    int errors = 0;
    int sb[$];
    int mr, mc;
    int n_out, n_done, w_idx;
    int acc_cyc, first_out, stream_cyc, stall_ok, last_out;
    bit timed_out;

    always #5 clk = ~clk;

    conv_sequencer #(
        .KERN_DIM  (K),
        .DATA_WIDTH(16),
        .IMG_W     (W),
        .IMG_H     (H),
        .DP_LAT    (L)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_we     (w_we),
        .w_addr   (w_addr),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .px_we    (px_we),
        .win_valid(win_valid),
        .dp_ce    (dp_ce),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row  (out_row),
        .out_col  (out_col)
    );

    // Drives one frame; wpct/ppct are valid percentages, omode picks the
    // out_ready pattern (0 always, 1 random, 2 five-cycle stall), spct is the
    // stray start percentage, abort_at the cycle that pulls reset (-1 none).
    task automatic run_frame(input int wpct, input int ppct, input int omode,
                             input int spct, input int abort_at);
        int st;
        bit hold;
        bit ew;
        logic [2:0] hrow, hcol;
        int got, exp_v;
        mr = 0; mc = 0; sb.delete();
        n_out = 0; n_done = 0; w_idx = 0;
        acc_cyc = -1; first_out = -1; stream_cyc = -1;
        stall_ok = 0; last_out = -1; timed_out = 0;
        st = 0; hold = 0; hrow = '0; hcol = '0;
        @(negedge clk);
        start = 1'b1; w_valid = 1'b0; px_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start    = (spct > 0) && (($urandom_range(99) < spct) || done);
            w_valid  = ($urandom_range(99) < wpct);
            px_valid = ($urandom_range(99) < ppct);
            if (omode == 2 && out_valid && st < 5) begin
                out_ready = 1'b0;
                st++;
            end else if (omode == 1) begin
                out_ready = 1'($urandom_range(1));
            end else begin
                out_ready = 1'b1;
            end
            if (cyc == abort_at) begin
                rstn = 1'b0;
                #1;
                return;
            end
            #1;
            if (stream_cyc < 0 && px_ready === 1'b1) stream_cyc = cyc;
            if (omode == 2 && out_valid && !out_ready)
                if (dp_ce === 1'b0 && px_ready === 1'b0) stall_ok++;
            checks++;
            if (w_we !== (w_valid & w_ready)) begin
                errors++;
                $display("FAIL w_we got %b want %b", w_we, w_valid & w_ready);
            end
            if (w_we === 1'b1) begin
                checks++;
                if (w_addr !== 4'(w_idx)) begin
                    errors++;
                    $display("FAIL w_addr got %0d want %0d", w_addr, w_idx);
                end
                w_idx++;
            end
            checks++;
            if (dp_ce !== (~out_valid | out_ready)) begin
                errors++;
                $display("FAIL dp_ce got %b want %b", dp_ce,
                         ~out_valid | out_ready);
            end
            if (px_valid && px_ready) begin
                ew = (mr >= K - 1) && (mc >= K - 1);
                checks++;
                if (px_we !== 1'b1 || win_valid !== ew) begin
                    errors++;
                    $display("FAIL win r%0d c%0d got we=%b win=%b want 1 %b",
                             mr, mc, px_we, win_valid, ew);
                end
                if (ew) sb.push_back((mr - (K - 1)) * 256 + (mc - (K - 1)));
                if (mr == K - 1 && mc == K - 1) acc_cyc = cyc;
                if (mc == W - 1) begin
                    mc = 0;
                    mr++;
                end else begin
                    mc++;
                end
            end else begin
                checks++;
                if (px_we !== 1'b0 || win_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL px_idle got we=%b win=%b want 0 0",
                             px_we, win_valid);
                end
            end
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_row !== hrow ||
                    out_col !== hcol) begin
                    errors++;
                    $display("FAIL hold got v%b (%0d,%0d) want v1 (%0d,%0d)",
                             out_valid, out_row, out_col, hrow, hcol);
                end
            end
            if (out_valid === 1'b1 && first_out < 0) first_out = cyc;
            if (out_valid && out_ready) begin
                n_out++;
                got = int'(out_row) * 256 + int'(out_col);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_out got %0d want none", got);
                end else begin
                    exp_v = sb.pop_front();
                    if (got !== exp_v) begin
                        errors++;
                        $display("FAIL order got %0d want %0d", got, exp_v);
                    end
                end
                last_out = got;
            end
            hold = out_valid && !out_ready;
            hrow = out_row;
            hcol = out_col;
            if (done === 1'b1) begin
                n_done++;
                return;
            end
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; start = 1'b0; w_valid = 1'b1; px_valid = 1'b1;
        out_ready = 1'b0;
        #3;
        checks++;
        if ({busy, done, w_ready, px_ready, w_we, px_we, win_valid,
             out_valid} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0",
                     {busy, done, w_ready, px_ready, w_we, px_we, win_valid,
                      out_valid});
        end
        checks++;
        if (dp_ce !== 1'b1) begin
            errors++;
            $display("FAIL reset_ce got %b want 1", dp_ce);
        end
        checks++;
        if (out_row !== 3'd0 || out_col !== 3'd0 || w_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_pos got %0d %0d %0d want 0 0 0",
                     out_row, out_col, w_addr);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || w_we !== 1'b0 || px_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore got b%b w%b p%b want 0 0 0",
                     busy, w_we, px_we);
        end
        w_valid = 1'b0; px_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_full_rate;
        run_frame(100, 100, 0, 0, -1);
        checks++;
        if (w_idx !== K * K || stream_cyc !== K * K) begin
            errors++;
            $display("FAIL load got w%0d s%0d want %0d %0d",
                     w_idx, stream_cyc, K * K, K * K);
        end
        checks++;
        if (n_out !== NOUT || sb.size() !== 0 || timed_out) begin
            errors++;
            $display("FAIL full_count got %0d left %0d to %0d want %0d 0 0",
                     n_out, sb.size(), timed_out, NOUT);
        end
        checks++;
        if (acc_cyc < 0 || first_out !== acc_cyc + L) begin
            errors++;
            $display("FAIL latency got %0d want %0d", first_out, acc_cyc + L);
        end
        checks++;
        if (last_out !== 3 * 256 + 3 || n_done !== 1) begin
            errors++;
            $display("FAIL last got %0d d%0d want %0d d1",
                     last_out, n_done, 3 * 256 + 3);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_done got b%b d%b want 0 0", busy, done);
        end
    endtask

    task automatic test_stall;
        run_frame(100, 100, 2, 0, -1);
        checks++;
        if (stall_ok !== 5) begin
            errors++;
            $display("FAIL stall got %0d want 5", stall_ok);
        end
        checks++;
        if (n_out !== NOUT || sb.size() !== 0 || n_done !== 1 || timed_out) begin
            errors++;
            $display("FAIL stall_count got %0d left %0d d%0d want %0d 0 1",
                     n_out, sb.size(), n_done, NOUT);
        end
    endtask

    task automatic test_random_gaps;
        for (int k = 0; k < 2; k++) begin
            run_frame(50, 50, 1, 0, -1);
            checks++;
            if (n_out !== NOUT || sb.size() !== 0 || n_done !== 1 ||
                timed_out) begin
                errors++;
                $display("FAIL gap_count got %0d left %0d d%0d want %0d 0 1",
                         n_out, sb.size(), n_done, NOUT);
            end
        end
    endtask

    task automatic test_reset_mid;
        run_frame(100, 100, 0, 0, 20);
        checks++;
        if ({busy, done, w_ready, px_ready, w_we, px_we, win_valid,
             out_valid} !== 8'b0 || dp_ce !== 1'b1) begin
            errors++;
            $display("FAIL abort_ctl got %b ce%b want 0 ce1",
                     {busy, done, w_ready, px_ready, w_we, px_we, win_valid,
                      out_valid}, dp_ce);
        end
        checks++;
        if (out_row !== 3'd0 || out_col !== 3'd0 || n_done !== 0) begin
            errors++;
            $display("FAIL abort_pos got %0d %0d d%0d want 0 0 d0",
                     out_row, out_col, n_done);
        end
        @(negedge clk);
        rstn = 1'b1;
        run_frame(100, 100, 0, 0, -1);
        checks++;
        if (n_out !== NOUT || sb.size() !== 0 || n_done !== 1 || timed_out) begin
            errors++;
            $display("FAIL rerun got %0d left %0d d%0d want %0d 0 1",
                     n_out, sb.size(), n_done, NOUT);
        end
    endtask

    task automatic test_start_ignored;
        run_frame(100, 100, 0, 30, -1);
        checks++;
        if (n_out !== NOUT || sb.size() !== 0 || n_done !== 1 || timed_out) begin
            errors++;
            $display("FAIL start_frame got %0d left %0d d%0d want %0d 0 1",
                     n_out, sb.size(), n_done, NOUT);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_at_done got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_stall();
        test_random_gaps();
        test_reset_mid();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
